// File: rtl/mm_pkg.sv
// mm_pkg: shared definitions for the Mastermind scoring core.
//   - state encoding for the engine FSM
//   - width helpers for counter/score ports
//   - peg extraction from a packed code/guess bus
package mm_pkg;

    // Engine FSM encoding.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_READY  = 3'd1;
    localparam state_t ST_EXACT  = 3'd2;
    localparam state_t ST_COLOR  = 3'd3;
    localparam state_t ST_REPORT = 3'd4;
    localparam state_t ST_WON    = 3'd5;
    localparam state_t ST_LOST   = 3'd6;

    // Upper bounds for get_peg: packed buses up to 256 bits, pegs up to 16 bits.
    localparam int unsigned MAX_BUS_W   = 256;
    localparam int unsigned MAX_COLOR_W = 16;

    // Bits needed to hold the values 0..n.
    function automatic int unsigned count_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Returns peg idx of a packed bus (peg i at bits [i*color_w +: color_w]),
    // zero-extended to MAX_COLOR_W bits. Callers truncate to their own COLOR_W.
    function automatic logic [MAX_COLOR_W-1:0] get_peg(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          color_w
    );
        logic [MAX_BUS_W-1:0]   shifted;
        logic [MAX_COLOR_W-1:0] mask;
        shifted = bus >> (idx * color_w);
        mask    = (MAX_COLOR_W'(1) << color_w) - MAX_COLOR_W'(1);
        return shifted[MAX_COLOR_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/mm_color_count.sv
// mm_color_count: combinational per-colour match counter.
// Counts how many code pegs and how many guess pegs equal the colour `color`
// and returns the smaller count, i.e. the number of colour matches
// (position-independent) contributed by that colour.
//   code   in  PEGS*COLOR_W  packed secret code
//   guess  in  PEGS*COLOR_W  packed guess
//   color  in  COLOR_W       colour under test
//   min_count out CW         min(count_code(color), count_guess(color))
module mm_color_count
    import mm_pkg::*;
#(
    parameter int unsigned PEGS    = 4,
    parameter int unsigned COLOR_W = 3,
    localparam int unsigned CW     = count_w(PEGS)
) (
    input  logic [PEGS*COLOR_W-1:0] code,
    input  logic [PEGS*COLOR_W-1:0] guess,
    input  logic [COLOR_W-1:0]      color,
    output logic [CW-1:0]           min_count
);

    logic [CW-1:0] cnt_code;
    logic [CW-1:0] cnt_guess;

    always_comb begin
        cnt_code  = '0;
        cnt_guess = '0;
        for (int unsigned i = 0; i < PEGS; i++) begin
            if (COLOR_W'(get_peg(MAX_BUS_W'(code), i, COLOR_W)) == color) begin
                cnt_code = cnt_code + CW'(1);
            end
            if (COLOR_W'(get_peg(MAX_BUS_W'(guess), i, COLOR_W)) == color) begin
                cnt_guess = cnt_guess + CW'(1);
            end
        end
        min_count = (cnt_code < cnt_guess) ? cnt_code : cnt_guess;
    end

endmodule

// File: rtl/mm_score_engine.sv
// mm_score_engine: sequential Mastermind scoring core.
// Holds a PEGS-peg secret code, accepts guesses over valid/ready, scores each
// one peg-by-peg (exact hits) then colour-by-colour (total colour matches),
// and reports exact/partial counts with a one-cycle result_valid pulse.
// Tracks the turn count against TURNS and flags win/lose.
//   clk, reset_n   clock, asynchronous active-low reset
//   new_game       synchronous abort back to IDLE
//   code_load      latch code_in (IDLE, WON, LOST only)
//   code_in        packed secret code
//   guess_valid    guess offered
//   guess          packed guess
//   guess_ready    high in READY
//   exact/partial  score of the last guess
//   result_valid   one-cycle pulse in REPORT
//   turn           guesses scored this game
//   win/lose       levels in WON/LOST
module mm_score_engine
    import mm_pkg::*;
#(
    parameter int unsigned PEGS    = 4,
    parameter int unsigned COLOR_W = 3,
    parameter int unsigned TURNS   = 8,
    localparam int unsigned CW     = count_w(PEGS),
    localparam int unsigned TW     = count_w(TURNS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    new_game,
    input  logic                    code_load,
    input  logic [PEGS*COLOR_W-1:0] code_in,
    input  logic                    guess_valid,
    input  logic [PEGS*COLOR_W-1:0] guess,
    output logic                    guess_ready,
    output logic [CW-1:0]           exact,
    output logic [CW-1:0]           partial,
    output logic                    result_valid,
    output logic [TW-1:0]           turn,
    output logic                    win,
    output logic                    lose
);

    localparam int unsigned NCOL  = 2 ** COLOR_W;
    localparam int unsigned PW    = (PEGS > 1) ? $clog2(PEGS) : 1;
    // One counter serves as peg index in EXACT and colour in COLOR.
    localparam int unsigned CNT_W = (PW > COLOR_W) ? PW : COLOR_W;
    localparam int unsigned BW    = PEGS * COLOR_W;

    state_t            state_q, state_d;
    logic [BW-1:0]     code_q, code_d;
    logic [BW-1:0]     guess_q, guess_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]     exact_acc_q, exact_acc_d;
    logic [CW-1:0]     match_acc_q, match_acc_d;
    logic [CW-1:0]     exact_q, exact_d;
    logic [CW-1:0]     partial_q, partial_d;
    logic [TW-1:0]     turn_q, turn_d;

    logic [COLOR_W-1:0] code_peg;
    logic [COLOR_W-1:0] guess_peg;
    logic [CW-1:0]      color_min;
    logic [CW-1:0]      match_next;
    logic               last_peg;
    logic               last_color;

    mm_color_count #(
        .PEGS    (PEGS),
        .COLOR_W (COLOR_W)
    ) u_color_count (
        .code      (code_q),
        .guess     (guess_q),
        .color     (cnt_q[COLOR_W-1:0]),
        .min_count (color_min)
    );

    assign code_peg   = COLOR_W'(get_peg(MAX_BUS_W'(code_q), 32'(cnt_q), COLOR_W));
    assign guess_peg  = COLOR_W'(get_peg(MAX_BUS_W'(guess_q), 32'(cnt_q), COLOR_W));
    assign last_peg   = (cnt_q == CNT_W'(PEGS - 1));
    assign last_color = (cnt_q == CNT_W'(NCOL - 1));
    assign match_next = match_acc_q + color_min;

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        guess_d     = guess_q;
        cnt_d       = cnt_q;
        exact_acc_d = exact_acc_q;
        match_acc_d = match_acc_q;
        exact_d     = exact_q;
        partial_d   = partial_q;
        turn_d      = turn_q;

        if (new_game) begin
            state_d = ST_IDLE;
            turn_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_WON, ST_LOST: begin
                    if (code_load) begin
                        code_d    = code_in;
                        turn_d    = '0;
                        exact_d   = '0;
                        partial_d = '0;
                        state_d   = ST_READY;
                    end
                end
                ST_READY: begin
                    if (guess_valid) begin
                        guess_d     = guess;
                        exact_acc_d = '0;
                        match_acc_d = '0;
                        cnt_d       = '0;
                        state_d     = ST_EXACT;
                    end
                end
                ST_EXACT: begin
                    if (code_peg == guess_peg) begin
                        exact_acc_d = exact_acc_q + CW'(1);
                    end
                    if (last_peg) begin
                        cnt_d   = '0;
                        state_d = ST_COLOR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_COLOR: begin
                    match_acc_d = match_next;
                    if (last_color) begin
                        // Outputs are registered here so they are visible
                        // during the REPORT cycle alongside result_valid.
                        exact_d   = exact_acc_q;
                        partial_d = match_next - exact_acc_q;
                        turn_d    = turn_q + TW'(1);
                        cnt_d     = '0;
                        state_d   = ST_REPORT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (exact_q == CW'(PEGS)) begin
                        state_d = ST_WON;
                    end else if (turn_q == TW'(TURNS)) begin
                        state_d = ST_LOST;
                    end else begin
                        state_d = ST_READY;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            code_q      <= '0;
            guess_q     <= '0;
            cnt_q       <= '0;
            exact_acc_q <= '0;
            match_acc_q <= '0;
            exact_q     <= '0;
            partial_q   <= '0;
            turn_q      <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            guess_q     <= guess_d;
            cnt_q       <= cnt_d;
            exact_acc_q <= exact_acc_d;
            match_acc_q <= match_acc_d;
            exact_q     <= exact_d;
            partial_q   <= partial_d;
            turn_q      <= turn_d;
        end
    end

    assign guess_ready  = (state_q == ST_READY);
    assign result_valid = (state_q == ST_REPORT);
    assign win          = (state_q == ST_WON);
    assign lose         = (state_q == ST_LOST);
    assign exact        = exact_q;
    assign partial      = partial_q;
    assign turn         = turn_q;

endmodule

// File: tb/tb_mm_score_engine.sv
// Bench for mm_score_engine (PEGS=4, COLOR_W=3, TURNS=8): directed scenarios
// plus randomized games, checked against a classic peg-marking scoring model.
module tb_mm_score_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        new_game = 1'b0;
    logic        code_load = 1'b0;
    logic [11:0] code_in = '0;
    logic        guess_valid = 1'b0;
    logic [11:0] guess = '0;
    logic        guess_ready;
    logic [2:0]  exact;
    logic [2:0]  partial;
    logic        result_valid;
    logic [3:0]  turn;
    logic        win;
    logic        lose;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state.
    logic [11:0] mcode = '0;
    int          mturn = 0;
    bit          mwon  = 0;
    bit          mlost = 0;

    mm_score_engine #(
        .PEGS    (4),
        .COLOR_W (3),
        .TURNS   (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .new_game     (new_game),
        .code_load    (code_load),
        .code_in      (code_in),
        .guess_valid  (guess_valid),
        .guess        (guess),
        .guess_ready  (guess_ready),
        .exact        (exact),
        .partial      (partial),
        .result_valid (result_valid),
        .turn         (turn),
        .win          (win),
        .lose         (lose)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pk(input int p0, input int p1, input int p2, input int p3);
        return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    // Mastermind scoring by marking: exact pegs first, then pair each remaining
    // guess peg with an unused code peg of the same colour.
    function automatic void model_score(input logic [11:0] c, input logic [11:0] g,
                                        output int ex, output int pa);
        logic [2:0] cp[4];
        logic [2:0] gp[4];
        bit uc[4];
        bit ug[4];
        bit done;
        ex = 0;
        pa = 0;
        for (int i = 0; i < 4; i++) begin
            cp[i] = c[i*3 +: 3];
            gp[i] = g[i*3 +: 3];
            uc[i] = 0;
            ug[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (cp[i] == gp[i]) begin
                ex++;
                uc[i] = 1;
                ug[i] = 1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!ug[i]) begin
                done = 0;
                for (int j = 0; j < 4; j++) begin
                    if (!done && !uc[j] && cp[j] == gp[i]) begin
                        pa++;
                        uc[j] = 1;
                        done = 1;
                    end
                end
            end
        end
    endfunction

    // Load a code from IDLE/WON/LOST and check the fresh-game outputs.
    task automatic load(input logic [11:0] c);
        code_load = 1'b1;
        code_in   = c;
        tick();
        code_load = 1'b0;
        mcode = c;
        mturn = 0;
        mwon  = 0;
        mlost = 0;
        chk("load_ready", 32'(guess_ready), 1);
        chk("load_turn", 32'(turn), 0);
        chk("load_exact", 32'(exact), 0);
        chk("load_partial", 32'(partial), 0);
        chk("load_win", 32'(win), 0);
        chk("load_lose", 32'(lose), 0);
    endtask

    task automatic abort();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        mturn = 0;
        mwon  = 0;
        mlost = 0;
        chk("abort_ready", 32'(guess_ready), 0);
        chk("abort_turn", 32'(turn), 0);
    endtask

    // Offer one guess in READY (optionally with a code_load that must be
    // ignored) and check latency, score and the follow-on state.
    task automatic play(input logic [11:0] g, input bit with_load, input logic [11:0] ld);
        int lat;
        int ex;
        int pa;
        chk("ready_pre", 32'(guess_ready), 1);
        guess_valid = 1'b1;
        guess       = g;
        if (with_load) begin
            code_load = 1'b1;
            code_in   = ld;
        end
        tick();
        guess_valid = 1'b0;
        code_load   = 1'b0;
        lat = 1;
        while (result_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 13);
        model_score(mcode, g, ex, pa);
        mturn++;
        chk("exact", 32'(exact), 32'(ex));
        chk("partial", 32'(partial), 32'(pa));
        chk("turn", 32'(turn), 32'(mturn));
        tick();
        if (ex == 4) mwon = 1;
        else if (mturn == 8) mlost = 1;
        chk("rv_pulse", 32'(result_valid), 0);
        chk("ready_post", 32'(guess_ready), 32'(!(mwon || mlost)));
        chk("win", 32'(win), 32'(mwon));
        chk("lose", 32'(lose), 32'(mlost));
        chk("turn_hold", 32'(turn), 32'(mturn));
    endtask

    function automatic logic [11:0] rand_code();
        return 12'($urandom);
    endfunction

    initial begin
        int rv_cnt;
        int rdy_cnt;
        logic [11:0] g;

        // Reset state.
        #12;
        chk("rst_exact", 32'(exact), 0);
        chk("rst_turn", 32'(turn), 0);
        chk("rst_rv", 32'(result_valid), 0);
        chk("rst_ready", 32'(guess_ready), 0);
        reset_n = 1'b1;
        tick();

        // Exact match wins.
        load(pk(1, 2, 3, 4));
        play(pk(1, 2, 3, 4), 0, '0);
        // Permutation, loaded from WON.
        load(pk(1, 2, 3, 4));
        play(pk(4, 3, 2, 1), 0, '0);

        // Duplicate colours.
        abort();
        load(pk(1, 1, 2, 2));
        play(pk(1, 2, 1, 3), 0, '0);
        play(pk(7, 7, 7, 7), 0, '0);

        // Turn exhaustion.
        abort();
        load(rand_code());
        for (int t = 0; t < 8; t++) begin
            g = rand_code();
            if (g == mcode) g = g ^ 12'h001;
            play(g, 0, '0);
        end
        guess_valid = 1'b1;
        guess       = mcode;
        rv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (result_valid) rv_cnt++;
        end
        guess_valid = 1'b0;
        chk("lost_ignore_rv", 32'(rv_cnt), 0);
        chk("lost_turn", 32'(turn), 8);
        chk("lost_lose", 32'(lose), 1);
        load(rand_code());

        // new_game during COLOR.
        abort();
        load(pk(1, 2, 3, 4));
        play(pk(1, 2, 0, 0), 0, '0);
        guess_valid = 1'b1;
        guess       = pk(1, 2, 3, 5);
        tick();
        guess_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        abort();
        rv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (result_valid) rv_cnt++;
        end
        chk("abort_no_rv", 32'(rv_cnt), 0);

        // Asynchronous reset mid-EXACT.
        load(pk(1, 2, 3, 4));
        play(pk(1, 5, 5, 5), 0, '0);
        guess_valid = 1'b1;
        guess       = pk(1, 2, 5, 5);
        tick();
        guess_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        chk("arst_exact", 32'(exact), 0);
        chk("arst_partial", 32'(partial), 0);
        chk("arst_turn", 32'(turn), 0);
        chk("arst_rv", 32'(result_valid), 0);
        chk("arst_win_lose", 32'({win, lose}), 0);
        chk("arst_ready", 32'(guess_ready), 0);
        #2;
        reset_n = 1'b1;
        mturn = 0;
        mwon  = 0;
        mlost = 0;
        tick();

        // guess_valid in IDLE is ignored.
        guess_valid = 1'b1;
        guess       = pk(3, 3, 3, 3);
        rv_cnt  = 0;
        rdy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (result_valid) rv_cnt++;
            if (guess_ready) rdy_cnt++;
        end
        guess_valid = 1'b0;
        chk("idle_no_rv", 32'(rv_cnt), 0);
        chk("idle_no_ready", 32'(rdy_cnt), 0);

        // code_load in READY is ignored; old code scores the guess.
        load(pk(1, 2, 3, 4));
        play(pk(5, 6, 7, 0), 1, pk(5, 6, 7, 0));
        play(pk(5, 6, 7, 0), 0, '0);

        // Randomized games.
        for (int gm = 0; gm < 6; gm++) begin
            abort();
            load(rand_code());
            for (int t = 0; t < 8 && !mwon && !mlost; t++) begin
                if ($urandom_range(3) == 0) g = mcode;
                else if ($urandom_range(1) == 0) g = {mcode[5:0], mcode[11:6]};
                else g = rand_code();
                play(g, 0, '0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
